// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor.
// Holds the FSM state encoding and the digit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for ndig digits; never narrower than one bit.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple of full-subtractor cells: d = x - y - bin.
// bout is the borrow out of the most significant cell.
module digit_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] br;

    assign br[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign d[i]    = x[i] ^ y[i] ^ br[i];
        assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end

    assign bout = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, DIGIT bits per clock, LSB first.
// start/busy/done handshake; result and flags are registered at the completion edge.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int            NDIG = WIDTH / DIGIT;
    localparam int            CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state, state_nxt;
    logic             accept;
    logic             last;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             borrow;
    logic             a_msb, b_msb;

    logic [DIGIT-1:0]       dig_d;
    logic                   dig_bout;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_nxt;

    digit_subtractor #(.DIGIT(DIGIT)) u_digit (
        .x    (a_sh[DIGIT-1:0]),
        .y    (b_sh[DIGIT-1:0]),
        .bin  (borrow),
        .d    (dig_d),
        .bout (dig_bout)
    );

    // New digit enters from the top so the LSB digit ends up at the bottom.
    assign res_cat = {dig_d, res_sh};
    assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign last    = (cnt == LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN:     if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done come straight from flops so outputs have no decode logic behind them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values regardless of statement order.
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shift registers are cleared too, so an aborted operation leaves nothing behind.
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= borrow_in;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
        end else if (state == RUN) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            res_sh <= res_nxt;
            borrow <= dig_bout;
            cnt    <= cnt + CW'(1);
            if (last) begin
                diff       <= res_nxt;
                borrow_out <= dig_bout;
                overflow   <= (a_msb ^ b_msb) & (res_nxt[WIDTH-1] ^ a_msb);
                zero       <= (res_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH/DIGIT = 16/4, 4/1 and 4/4.
// Expected values are hand-computed constants or a 5-bit behavioural subtraction.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        start16 = 1'b0, bin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, bo16, ovf16, z16;
    logic [15:0] diff16;

    logic       start4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       s1_busy, s1_done, s1_bo, s1_ovf, s1_z;
    logic [3:0] s1_diff;
    logic       s4_busy, s4_done, s4_bo, s4_ovf, s4_z;
    logic [3:0] s4_diff;

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .borrow_in(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16),
        .overflow(ovf16), .zero(z16)
    );

    serial_subtractor #(.WIDTH(4), .DIGIT(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
        .busy(s1_busy), .done(s1_done), .diff(s1_diff), .borrow_out(s1_bo),
        .overflow(s1_ovf), .zero(s1_z)
    );

    serial_subtractor #(.WIDTH(4), .DIGIT(4)) dut_s4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
        .busy(s4_busy), .done(s4_done), .diff(s4_diff), .borrow_out(s4_bo),
        .overflow(s4_ovf), .zero(s4_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out16(input string tag, input logic [15:0] e_diff,
                               input logic e_bo, input logic e_ovf, input logic e_z);
        check({tag, "_diff"}, diff16, e_diff);
        check({tag, "_borrow"}, bo16, e_bo);
        check({tag, "_ovf"}, ovf16, e_ovf);
        check({tag, "_zero"}, z16, e_z);
    endtask

    // One full operation on the 16/4 instance, with latency and busy-length checks.
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic [15:0] e_diff,
                         input logic e_bo, input logic e_ovf, input logic e_z);
        int k;
        int busy_n;
        @(negedge clk);
        a16 = a; b16 = b; bin16 = bin; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; a16 = ~a; b16 = ~b; bin16 = ~bin;
        k = 0;
        busy_n = 0;
        while (!done16 && k < 30) begin
            if (busy16) busy_n++;
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, 4);
        check({tag, "_busy_cycles"}, busy_n, 4);
        check_out16(tag, e_diff, e_bo, e_ovf, e_z);
        @(negedge clk);
        check({tag, "_done_width"}, done16, 1'b0);
    endtask

    initial begin
        int done_at1;
        int done_at2;
        logic [4:0] full;
        logic [3:0] m_diff;
        logic       m_ovf;
        logic       seen1, seen4;
        string      t;

        repeat (2) @(negedge clk);
        check("reset_busy", busy16, 1'b0);
        check("reset_done", done16, 1'b0);
        check_out16("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        run16("v1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run16("v2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run16("v3", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run16("v4", 16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        run16("v5", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

        // Start pulsed mid-RUN is ignored; start held through DONE is accepted at E5.
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h0234; bin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        done_at1 = -1;
        done_at2 = -1;
        for (int k = 0; k <= 12; k++) begin
            if (done16) begin
                if (done_at1 < 0) begin
                    done_at1 = k;
                    check_out16("b2b_first", 16'h1000, 1'b0, 1'b0, 1'b0);
                end else if (done_at2 < 0) begin
                    done_at2 = k;
                    check_out16("b2b_second", 16'hFFFF, 1'b1, 1'b0, 1'b0);
                end
            end
            if (k == 5) check("b2b_busy_again", busy16, 1'b1);
            if (k == 1) begin start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; end
            if (k == 2) start16 = 1'b0;
            if (k == 3) begin start16 = 1'b1; a16 = 16'h00FF; b16 = 16'h0100; bin16 = 1'b0; end
            if (k == 5) start16 = 1'b0;
            @(negedge clk);
        end
        check("b2b_done1_at", done_at1, 4);
        check("b2b_done2_at", done_at2, 9);

        // Asynchronous reset in RUN cycle 2, applied away from any clock edge.
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h0234; bin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", busy16, 1'b0);
        check("arst_done", done16, 1'b0);
        check("arst_state", dut16.state, IDLE);
        check_out16("arst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run16("post_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep on both small configurations at once.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    seen1 = 1'b0;
                    seen4 = 1'b0;
                    repeat (5) begin
                        if (s1_done) seen1 = 1'b1;
                        if (s4_done) seen4 = 1'b1;
                        @(negedge clk);
                    end
                    full   = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(ic);
                    m_diff = full[3:0];
                    m_ovf  = (ia[3] != ib[3]) && (m_diff[3] != ia[3]);
                    t = $sformatf("a=%0d b=%0d bin=%0d", ia, ib, ic);
                    check({"d1 done ", t}, seen1, 1'b1);
                    check({"d1 diff ", t}, s1_diff, m_diff);
                    check({"d1 borrow ", t}, s1_bo, full[4]);
                    check({"d1 ovf ", t}, s1_ovf, m_ovf);
                    check({"d1 zero ", t}, s1_z, (m_diff == 4'd0));
                    check({"d4 done ", t}, seen4, 1'b1);
                    check({"d4 diff ", t}, s4_diff, m_diff);
                    check({"d4 borrow ", t}, s4_bo, full[4]);
                    check({"d4 ovf ", t}, s4_ovf, m_ovf);
                    check({"d4 zero ", t}, s4_z, (m_diff == 4'd0));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised digit-serial subtractor computing A − B − borrow_in over WIDTH bits, DIGIT bits per clock, LSB digit first. It is the sequential successor to the single-bit half/full subtractor cells. It trades latency for area in datapaths where a full-width ripple or lookahead subtractor is too large. A start/busy/done handshake and registered result flags (borrow, signed overflow, zero) let it slot behind a simple controller.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT, ≥ 2
- DIGIT, 4, bits processed per RUN cycle; 1 ≤ DIGIT ≤ WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend, captured at the accepting edge
- b  input  WIDTH  subtrahend, captured at the accepting edge
- borrow_in  input  1  initial borrow, captured at the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse in DONE
- diff  output  WIDTH  registered result a − b − borrow_in mod 2^WIDTH
- borrow_out  output  1  final borrow (unsigned a < b + borrow_in)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  diff == 0

## Operation
- NDIG = WIDTH/DIGIT. FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1: capture a, b, borrow_in into operand shift registers, clear digit counter, go to RUN. With start=0: DONE → IDLE, IDLE stays.
- RUN: each cycle, subtract the low DIGIT bits of the operand registers with the running borrow. Shift the digit difference into the result shift register from the top. Shift the operands right by DIGIT. Update the borrow. Increment the counter.
- On the RUN cycle with counter = NDIG−1: load diff, borrow_out, overflow and zero from the final values, then go to DONE.
- overflow = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]), using captured operands. borrow_in participates in the borrow chain only.
- start during RUN is ignored; operands are not recaptured.
- diff and the flags change only at the completion edge. They hold the last result through IDLE and the next RUN.
- Reset, asynchronous and at any time including mid-RUN:
  - state = IDLE.
  - busy, done, diff, borrow_out, overflow and zero all 0.
  - Counter and shift registers cleared.
  - The in-flight operation is discarded.

## Timing
- Edge E0 accepts start. busy = 1 from E0 until E_NDIG.
- Result, flags and done are valid in the cycle after E_NDIG. Latency is NDIG clocks from the accepting edge.
- done is high for exactly one cycle.
- Back-to-back: start held high in DONE is accepted at E_NDIG+1. Throughput is one result per NDIG+1 cycles.
- Inputs a, b and borrow_in matter only at the accepting edge. They may change at any other time.
- All outputs are driven by registers; there is no combinational input-to-output path.

## Structure
- Shared package serial_subtractor_pkg holds the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width helper (clog2 of NDIG, minimum 1).
- One sub-module, digit_subtractor, is a combinational DIGIT-bit ripple of full-subtractor cells.
  - Inputs: x[DIGIT], y[DIGIT], bin.
  - Outputs: d[DIGIT], bout.
  - It is instantiated once and reused every RUN cycle.
- The top level contains the FSM, counter, shift registers and result/flag registers.

## Test plan
Defaults are WIDTH=16, DIGIT=4 (NDIG=4) unless stated otherwise.
- a=0x1234, b=0x0234, bin=0 → diff=0x1000, borrow_out=0, overflow=0, zero=0; done pulses exactly 4 cycles after the start edge, and busy is high for 4 cycles.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, borrow_out=1, overflow=0. Then a=0x8000, b=0x0001 → diff=0x7FFF, borrow_out=0, overflow=1.
- a=0x0005, b=0x0004, bin=1 → diff=0x0000, zero=1, borrow_out=0.
- Pulse start with new operands in cycle 2 of RUN → ignored; the result matches the first operands. Hold start high through DONE → second operation accepted at E5, with its done pulse 5 cycles after the first.
- Assert rst in RUN cycle 2 → all outputs 0 immediately with no clock edge needed, state IDLE. A following start gives the correct result.
- WIDTH=4, DIGIT=1 and WIDTH=4, DIGIT=4 → exhaustive check of all 512 (a, b, bin) combinations against a behavioural reference model for diff and all flags.
